// File: rtl/layer_out_serializer.sv
// ----------------------------------------------------------------------------
// layer_out_serializer
//
// Gathers one frame of NUM_NEURON per-neuron results from a fully-connected
// layer, whose valid pulses may arrive on different cycles. It then streams
// the frame one word at a time into the next layer, starting with element 0.
//
// Optional feature macro: LAYER_SER_ARGMAX_EN
//   When defined, the block tracks the signed maximum over each transmitted
//   frame. It reports the index of that maximum on o_argmax, together with
//   a one-cycle pulse on o_argmax_valid.
//
// Ports
//   i_clk           clock, rising-edge
//   i_reset         asynchronous, active-low reset
//   i_data          packed neuron outputs, neuron k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_data_valid    per-neuron capture pulse
//   o_data          current outgoing word (buffer entry selected by idx)
//   o_data_valid    o_data is valid (registered)
//   i_ready         downstream accepts the word
//   o_busy          high while sending (same as o_data_valid)
//   o_overrun       sticky: a neuron pulse was dropped while sending
//   o_argmax        index of the frame maximum      (LAYER_SER_ARGMAX_EN only)
//   o_argmax_valid  one-cycle result pulse          (LAYER_SER_ARGMAX_EN only)
// ----------------------------------------------------------------------------
module layer_out_serializer #(
   parameter int NUM_NEURON = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic                             i_clk,
   input  logic                             i_reset,
   input  logic [NUM_NEURON*DATA_WIDTH-1:0] i_data,
   input  logic [NUM_NEURON-1:0]            i_data_valid,
   output logic [DATA_WIDTH-1:0]            o_data,
   output logic                             o_data_valid,
   input  logic                             i_ready,
   output logic                             o_busy,
   output logic                             o_overrun
`ifdef LAYER_SER_ARGMAX_EN
   ,
   output logic [$clog2(NUM_NEURON)-1:0]    o_argmax,
   output logic                             o_argmax_valid
`endif
);

   localparam int IDX_W = $clog2(NUM_NEURON);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURON - 1);

   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_SEND    = 1'b1
   } state_t;

   state_t                state_r;
   logic [DATA_WIDTH-1:0] data_buf_r [NUM_NEURON];
   logic [NUM_NEURON-1:0] mask_r;
   logic [IDX_W-1:0]      idx_r;
   logic                  valid_r;
   logic                  overrun_r;

   logic                  final_xfer_s;
   logic                  capture_s;
   logic                  drop_s;
   logic [NUM_NEURON-1:0] mask_next_s;
   logic                  frame_done_s;

   // Classify this cycle: capture pulses, drop them, or complete the frame.
   always_comb begin
      final_xfer_s = 1'b0;
      capture_s    = 1'b0;
      drop_s       = 1'b0;
      mask_next_s  = mask_r | i_data_valid;
      frame_done_s = 1'b0;
      if (state_r == ST_SEND) begin
         final_xfer_s = i_ready && (idx_r == LAST_IDX);
         // Pulses on the final-transfer edge belong to the next frame.
         capture_s    = final_xfer_s;
         drop_s       = !final_xfer_s && (|i_data_valid);
      end else begin
         capture_s    = 1'b1;
         frame_done_s = &mask_next_s;
      end
   end

   // Capture the buffer, run the collect/send FSM, and track overrun.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_r   <= ST_COLLECT;
         mask_r    <= {NUM_NEURON{1'b0}};
         idx_r     <= {IDX_W{1'b0}};
         valid_r   <= 1'b0;
         overrun_r <= 1'b0;
         for (int k = 0; k < NUM_NEURON; k++) begin
            data_buf_r[k] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         for (int k = 0; k < NUM_NEURON; k++) begin
            if (capture_s && i_data_valid[k]) begin
               data_buf_r[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         if (drop_s) begin
            overrun_r <= 1'b1;
         end
         case (state_r)
            ST_COLLECT: begin
               if (frame_done_s) begin
                  state_r <= ST_SEND;
                  valid_r <= 1'b1;
                  idx_r   <= {IDX_W{1'b0}};
                  mask_r  <= {NUM_NEURON{1'b0}};
               end else begin
                  mask_r  <= mask_next_s;
               end
            end
            ST_SEND: begin
               if (final_xfer_s) begin
                  state_r <= ST_COLLECT;
                  valid_r <= 1'b0;
                  idx_r   <= {IDX_W{1'b0}};
                  // The mask was cleared on SEND entry, so the new frame
                  // starts from exactly this cycle's pulses.
                  mask_r  <= i_data_valid;
               end else if (i_ready) begin
                  idx_r   <= idx_r + IDX_W'(1);
               end
            end
            default: begin
               state_r <= ST_COLLECT;
               valid_r <= 1'b0;
               idx_r   <= {IDX_W{1'b0}};
               mask_r  <= {NUM_NEURON{1'b0}};
            end
         endcase
      end
   end

   assign o_data       = data_buf_r[idx_r];
   assign o_data_valid = valid_r;
   assign o_busy       = valid_r;
   assign o_overrun    = overrun_r;

`ifdef LAYER_SER_ARGMAX_EN
   logic signed [DATA_WIDTH-1:0] max_r;
   logic [IDX_W-1:0]             run_idx_r;
   logic [IDX_W-1:0]             argmax_r;
   logic                         argmax_valid_r;
   logic                         xfer_s;
   logic                         cand_gt_s;

   assign xfer_s    = valid_r && i_ready;
   // A strict compare keeps the earlier index on ties.
   assign cand_gt_s = $signed(o_data) > max_r;

   // Track the running signed maximum across words as they transfer.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         max_r          <= {DATA_WIDTH{1'b0}};
         run_idx_r      <= {IDX_W{1'b0}};
         argmax_r       <= {IDX_W{1'b0}};
         argmax_valid_r <= 1'b0;
      end else begin
         argmax_valid_r <= final_xfer_s;
         if (xfer_s) begin
            if (idx_r == {IDX_W{1'b0}}) begin
               max_r     <= $signed(o_data);
               run_idx_r <= {IDX_W{1'b0}};
            end else if (cand_gt_s) begin
               max_r     <= $signed(o_data);
               run_idx_r <= idx_r;
            end
            // The last element is folded in directly so that the result
            // is ready on the same edge as the final transfer.
            if (final_xfer_s) begin
               argmax_r <= cand_gt_s ? idx_r : run_idx_r;
            end
         end
      end
   end

   assign o_argmax       = argmax_r;
   assign o_argmax_valid = argmax_valid_r;
`endif

endmodule

// File: tb/tb_layer_out_serializer.sv
module tb_layer_out_serializer;
   localparam int N = 10;
   localparam int W = 16;

   logic             i_clk = 1'b0;
   logic             i_reset;
   logic [N*W-1:0]   i_data;
   logic [N-1:0]     i_data_valid;
   logic [W-1:0]     o_data;
   logic             o_data_valid;
   logic             i_ready;
   logic             o_busy;
   logic             o_overrun;
`ifdef LAYER_SER_ARGMAX_EN
   logic [$clog2(N)-1:0] o_argmax;
   logic                 o_argmax_valid;
`endif

   int errors   = 0;
   int checks   = 0;
   int xfer_cnt = 0;
   logic [W-1:0] exp_q [$];

   layer_out_serializer #(.NUM_NEURON(N), .DATA_WIDTH(W)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_data         (i_data),
      .i_data_valid   (i_data_valid),
      .o_data         (o_data),
      .o_data_valid   (o_data_valid),
      .i_ready        (i_ready),
      .o_busy         (o_busy),
      .o_overrun      (o_overrun)
`ifdef LAYER_SER_ARGMAX_EN
      ,
      .o_argmax       (o_argmax),
      .o_argmax_valid (o_argmax_valid)
`endif
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_word(input int k, input logic [W-1:0] v);
      i_data[k*W +: W] = v;
      i_data_valid[k]  = 1'b1;
   endtask

   // Pulse all neurons in one cycle with base+k and queue the expected frame.
   task automatic frame_all(input logic [W-1:0] base);
      i_data_valid = '0;
      for (int k = 0; k < N; k++) begin
         set_word(k, base + W'(k));
         exp_q.push_back(base + W'(k));
      end
      tick();
      i_data_valid = '0;
   endtask

   // Scoreboard monitor: compares each transferred word and checks stall hold.
   initial begin
      logic         stall_prev;
      logic [W-1:0] held;
      logic [W-1:0] exp_w;
      stall_prev = 1'b0;
      held       = '0;
      forever begin
         @(negedge i_clk);
         if (i_reset === 1'b1 && o_data_valid === 1'b1) begin
            if (stall_prev) check("hold_on_stall", o_data, held);
            if (i_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got %0h expected none", o_data);
               end else begin
                  exp_w = exp_q.pop_front();
                  check("word", o_data, exp_w);
               end
               xfer_cnt++;
               stall_prev = 1'b0;
            end else begin
               stall_prev = 1'b1;
               held       = o_data;
            end
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0;
      i_reset      = 1'b0;
      i_ready      = 1'b0;
      i_data       = '0;
      i_data_valid = '0;
      repeat (2) tick();
      check("rst_valid", o_data_valid, 1'b0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_overrun", o_overrun, 1'b0);
      check("rst_data", o_data, 16'h0000);
      check("rst_mask", dut.mask_r, 0);
      i_reset = 1'b1;
      tick();

      // Staggered capture, one neuron per cycle.
      i_ready = 1'b1;
      for (int k = 0; k < N; k++) begin
         i_data_valid = '0;
         set_word(k, 16'h0100 + W'(k));
         exp_q.push_back(16'h0100 + W'(k));
         tick();
      end
      i_data_valid = '0;
      check("t1_latency_valid", o_data_valid, 1'b1);
      check("t1_busy", o_busy, 1'b1);
      c0 = xfer_cnt;
      repeat (N) tick();
      check("t1_xfer_count", xfer_cnt - c0, N);
      check("t1_done_valid", o_data_valid, 1'b0);
      check("t1_overrun", o_overrun, 1'b0);

      // Simultaneous capture with a 1,0,0,1 backpressure pattern.
      frame_all(16'h0200);
      c0 = xfer_cnt;
      for (int cyc = 0; cyc < 60 && (xfer_cnt - c0) < N; cyc++) begin
         i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         tick();
      end
      i_ready = 1'b1;
      check("t2_xfer_count", xfer_cnt - c0, N);
      check("t2_overrun", o_overrun, 1'b0);

      // Pulse on the final-transfer edge seeds the next frame.
      frame_all(16'h0400);
      repeat (N - 1) tick();
      i_data_valid = '0;
      set_word(0, 16'h0ABC);
      tick();
      i_data_valid = '0;
      check("t4_overrun", o_overrun, 1'b0);
      check("t4_gap_valid", o_data_valid, 1'b0);
      exp_q.push_back(16'h0ABC);
      for (int k = 1; k < N; k++) begin
         set_word(k, 16'h0500 + W'(k));
         exp_q.push_back(16'h0500 + W'(k));
      end
      tick();
      i_data_valid = '0;
      check("t4_second_valid", o_data_valid, 1'b1);
      check("t4_second_word0", o_data, 16'h0ABC);
      repeat (N) tick();
      check("t4_done_valid", o_data_valid, 1'b0);

      // Overwrite in COLLECT, then a dropped pulse mid-SEND.
      i_ready = 1'b0;
      set_word(3, 16'h0011);
      tick();
      i_data_valid = '0;
      set_word(3, 16'h0022);
      tick();
      i_data_valid = '0;
      for (int k = 0; k < N; k++) begin
         if (k != 3) set_word(k, 16'h0300 + W'(k));
         exp_q.push_back((k == 3) ? 16'h0022 : 16'h0300 + W'(k));
      end
      tick();
      i_data_valid = '0;
      check("t3_overrun_before", o_overrun, 1'b0);
      check("t3_valid", o_data_valid, 1'b1);
      repeat (2) tick();
      i_ready = 1'b1;
      repeat (2) tick();
      set_word(5, 16'h0BAD);
      tick();
      i_data_valid = '0;
      check("t3_overrun_set", o_overrun, 1'b1);
      repeat (7) tick();
      check("t3_done_valid", o_data_valid, 1'b0);
      check("t3_overrun_sticky", o_overrun, 1'b1);
      check("t3_queue_empty", exp_q.size(), 0);

      // Asynchronous reset after word 4 of a frame.
      frame_all(16'h0600);
      repeat (5) tick();
      check("t5_remaining", exp_q.size(), 5);
      #2;
      i_reset = 1'b0;
      #1;
      check("t5_async_valid", o_data_valid, 1'b0);
      check("t5_async_busy", o_busy, 1'b0);
      check("t5_async_mask", dut.mask_r, 0);
      exp_q.delete();
      repeat (2) tick();
      i_reset = 1'b1;
      check("t5_overrun_cleared", o_overrun, 1'b0);
      tick();
      check("t5_idle_valid", o_data_valid, 1'b0);
      frame_all(16'h0700);
      check("t5_restart_word0", o_data, 16'h0700);
      c0 = xfer_cnt;
      repeat (N) tick();
      check("t5_xfer_count", xfer_cnt - c0, N);

`ifdef LAYER_SER_ARGMAX_EN
      begin
         logic [W-1:0] am_vals [N];
         am_vals = '{16'hFFFB, 16'h0007, 16'h7FFF, 16'h8000, 16'h7FFF,
                     16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
         i_data_valid = '0;
         for (int k = 0; k < N; k++) begin
            set_word(k, am_vals[k]);
            exp_q.push_back(am_vals[k]);
         end
         tick();
         i_data_valid = '0;
         repeat (N - 1) tick();
         check("am_valid_early", o_argmax_valid, 1'b0);
         tick();
         check("am_valid_pulse", o_argmax_valid, 1'b1);
         check("am_index", o_argmax, 2);
         tick();
         check("am_valid_drop", o_argmax_valid, 1'b0);
         check("am_index_hold", o_argmax, 2);
      end
`endif

      tick();
      check("final_queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
